// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-RAM arbiter.
package imem_pkg;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_LOAD = 1'b1
    } imem_state_e;

    localparam int unsigned GNT_FETCH  = 0;
    localparam int unsigned GNT_LOAD   = 1;
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

endpackage

// File: rtl/imem_rr_arb.sv
// Two-requester round-robin arbiter; on contention the requester not granted last wins.
module imem_rr_arb
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Holds the ID of the requester granted most recently.
    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b00: gnt = 2'b00;
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: gnt = last_q ? 2'b01 : 2'b10;
        endcase
        last_d = last_q;
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[GNT_LOAD];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'(GNT_FETCH);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port instruction RAM between CPU fetch and the program loader.
// Define IMEM_ARB_STATS_EN to add accepted-fetch and fetch-stall counters.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req_valid,
    output logic                  fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_rsp_valid,
    output logic [DATA_WIDTH-1:0] fetch_rsp_data,
    output logic                  fetch_rsp_err,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [3:0]            load_be,
    input  logic                  load_lock,
    output logic                  cpu_hold,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_fetch_cnt,
    output logic [31:0]           stat_stall_cnt
`endif
);

    imem_state_e state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [1:0]  arb_req, gnt;
    logic        fetch_acc, load_acc, fetch_misaligned;
    logic        unused_load_addr_bits;

    assign unused_load_addr_bits = ^load_addr[1:0];

    // In S_LOAD the fetch side is masked so the loader wins every cycle.
    always_comb begin
        arb_req = 2'b00;
        if (!reset) begin
            arb_req[GNT_LOAD]  = load_valid;
            arb_req[GNT_FETCH] = fetch_req_valid && (state_q == S_RUN);
        end
    end

    imem_rr_arb u_rr_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (!reset),
        .gnt     (gnt)
    );

    assign fetch_acc        = gnt[GNT_FETCH];
    assign load_acc         = gnt[GNT_LOAD];
    assign fetch_misaligned = (fetch_addr[1:0] != 2'b00);
    assign fetch_req_ready  = fetch_acc;
    assign load_ready       = !reset && ((state_q == S_LOAD) || load_acc);
    assign cpu_hold         = !reset && (state_q == S_LOAD);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (load_acc) begin
            mem_en    = 1'b1;
            mem_we    = load_be;
            mem_addr  = load_addr[ADDR_WIDTH-1:2];
            mem_wdata = load_data;
        end else if (fetch_acc && !fetch_misaligned) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr[ADDR_WIDTH-1:2];
        end
    end

    always_comb begin
        state_d     = load_lock ? S_LOAD : S_RUN;
        rsp_valid_d = fetch_acc;
        rsp_err_d   = fetch_acc && fetch_misaligned;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Reset also squashes a response whose read was already issued.
    assign fetch_rsp_valid = rsp_valid_q && !reset;
    assign fetch_rsp_err   = fetch_rsp_valid && rsp_err_q;
    assign fetch_rsp_data  = !fetch_rsp_valid ? '0 :
                             rsp_err_q        ? DATA_WIDTH'(INSTR_NOP) : mem_rdata;

`ifdef IMEM_ARB_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(fetch_acc);
        stall_cnt_d = stall_cnt_q + 32'(fetch_req_valid && !fetch_req_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_fetch_cnt = fetch_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: byte-level reference model checked every cycle plus directed literal checks.
module tb_imem_arbiter;

    logic        clk, reset;
    logic        fv, fetch_req_ready, fetch_rsp_valid, fetch_rsp_err;
    logic [9:0]  fetch_addr, load_addr;
    logic [31:0] fetch_rsp_data, load_data, mem_wdata, mem_rdata;
    logic        lv, load_ready, load_lock, cpu_hold, mem_en;
    logic [3:0]  load_be, mem_we;
    logic [7:0]  mem_addr;
`ifdef IMEM_ARB_STATS_EN
    logic [31:0] stat_fetch_cnt, stat_stall_cnt;
`endif

    imem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req_valid (fv),
        .fetch_req_ready (fetch_req_ready),
        .fetch_addr      (fetch_addr),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_data  (fetch_rsp_data),
        .fetch_rsp_err   (fetch_rsp_err),
        .load_valid      (lv),
        .load_ready      (load_ready),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .load_be         (load_be),
        .load_lock       (load_lock),
        .cpu_hold        (cpu_hold),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
`ifdef IMEM_ARB_STATS_EN
        ,
        .stat_fetch_cnt  (stat_fetch_cnt),
        .stat_stall_cnt  (stat_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Synchronous-read RAM attached to the mem_* port.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: byte-addressed memory, lock flag, last winner, one pending response.
    logic [7:0]  ref_bytes [1024];
    logic        m_locked, m_last_load, m_pend, m_pend_err;
    logic [31:0] m_pend_data, m_fetch_cnt, m_stall_cnt;
    logic        e_fr, e_lr, e_hold, e_en;
    logic [3:0]  e_we;
    logic [31:0] e_data;
    int          base;

    always @(negedge clk) begin
        if (reset) begin
            e_fr = 0; e_lr = 0; e_hold = 0; e_en = 0; e_we = 0;
            check("cyc_rsp_valid", fetch_rsp_valid, 0);
        end else begin
            e_fr   = !m_locked && fv && (!lv || m_last_load);
            e_lr   = m_locked || (lv && (!fv || !m_last_load));
            e_hold = m_locked;
            e_en   = (e_lr && lv) || (e_fr && fetch_addr[1:0] == 2'b00);
            e_we   = (e_lr && lv) ? load_be : 4'b0000;
            e_data = m_pend ? m_pend_data : 32'h0;
            check("cyc_rsp_valid", fetch_rsp_valid, m_pend);
            check("cyc_rsp_data", fetch_rsp_data, e_data);
            check("cyc_rsp_err", fetch_rsp_err, m_pend && m_pend_err);
`ifdef IMEM_ARB_STATS_EN
            check("cyc_stat_fetch", stat_fetch_cnt, m_fetch_cnt);
            check("cyc_stat_stall", stat_stall_cnt, m_stall_cnt);
`endif
        end
        check("cyc_fetch_ready", fetch_req_ready, e_fr);
        check("cyc_load_ready", load_ready, e_lr);
        check("cyc_cpu_hold", cpu_hold, e_hold);
        check("cyc_mem_en", mem_en, e_en);
        check("cyc_mem_we", mem_we, e_we);

        if (reset) begin
            m_locked = 0; m_last_load = 0; m_pend = 0;
            m_fetch_cnt = 0; m_stall_cnt = 0;
        end else begin
            m_pend = e_fr;
            if (e_fr) begin
                base        = {fetch_addr[9:2], 2'b00};
                m_pend_err  = (fetch_addr[1:0] != 2'b00);
                m_pend_data = m_pend_err ? 32'h0000_0013 :
                    {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
                m_last_load = 0;
                m_fetch_cnt++;
            end else if (fv) begin
                m_stall_cnt++;
            end
            if (e_lr && lv) begin
                base = {load_addr[9:2], 2'b00};
                for (int b = 0; b < 4; b++)
                    if (load_be[b]) ref_bytes[base+b] = load_data[8*b +: 8];
                m_last_load = 1;
            end
            m_locked = load_lock;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [9:0] a, output logic v, output logic [31:0] d,
                             output logic e, output logic en_acc, output logic ok);
        fv = 1; fetch_addr = a; ok = 0; en_acc = 0;
        for (int n = 0; n < 8 && !ok; n++) begin
            @(negedge clk);
            if (fetch_req_ready) begin
                ok = 1;
                en_acc = mem_en;
            end
            step();
        end
        fv = 0;
        @(negedge clk);
        v = fetch_rsp_valid; d = fetch_rsp_data; e = fetch_rsp_err;
        step();
    endtask

    logic [31:0] t1_exp [4];
    logic        r_v, r_e, r_en, r_ok;
    logic [31:0] r_d;

    initial begin
        t1_exp = '{32'h0403_0201, 32'h0807_0605, 32'h0c0b_0a09, 32'h100f_0e0d};
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;
        for (int k = 0; k < 16; k++) begin
            ram[k/4][8*(k%4) +: 8] = 8'(k + 1);
            ref_bytes[k] = 8'(k + 1);
        end
        reset = 1; fv = 1; fetch_addr = 0; lv = 0; load_addr = 0; load_data = 0;
        load_be = 0; load_lock = 0;

        // Reset state, with a fetch request present
        @(negedge clk);
        check("rst_fetch_ready", fetch_req_ready, 0);
        check("rst_rsp_valid", fetch_rsp_valid, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        step(); step();
        reset = 0; fv = 0;

        // 1: back-to-back aligned fetches
        for (int i = 0; i < 6; i++) begin
            fv = (i < 4); fetch_addr = 10'(4 * i);
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                check("t1_rsp_valid", fetch_rsp_valid, 1);
                check("t1_rsp_data", fetch_rsp_data, t1_exp[i-1]);
            end
            step();
        end

        // 2: contention after reset alternates starting with the loader
        reset = 1; step(); reset = 0;
        fv = 1; fetch_addr = 0; lv = 1; load_addr = 16; load_data = 32'h1122_3344; load_be = 4'hf;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_load_grant", load_ready, (i % 2 == 0));
            check("t2_fetch_grant", fetch_req_ready, (i % 2 == 1));
            step();
        end
        fv = 0; lv = 0; step(); step();

        // 3: lock, partial write, unlock, fetch back
        load_lock = 1; fv = 1; fetch_addr = 0;
        step();
        @(negedge clk);
        check("t3_cpu_hold", cpu_hold, 1);
        check("t3_fetch_blocked", fetch_req_ready, 0);
        step();
        lv = 1; load_addr = 0; load_data = 32'hdead_beef; load_be = 4'b0011;
        @(negedge clk);
        check("t3_load_ready", load_ready, 1);
        step();
        lv = 0; load_lock = 0;
        fetch_one(10'd0, r_v, r_d, r_e, r_en, r_ok);
        check("t3_accepted", r_ok, 1);
        check("t3_rsp_valid", r_v, 1);
        check("t3_rsp_data", r_d, 32'h0403_beef);

        // 4: misaligned fetch returns NOP with error and no RAM access
        fetch_one(10'd6, r_v, r_d, r_e, r_en, r_ok);
        check("t4_rsp_valid", r_v, 1);
        check("t4_rsp_err", r_e, 1);
        check("t4_rsp_data", r_d, 32'h0000_0013);
        check("t4_mem_en", r_en, 0);

        // 5: reset right after a fetch accept drops the response
        fv = 1; fetch_addr = 4;
        @(negedge clk);
        check("t5_accept", fetch_req_ready, 1);
        step();
        reset = 1; lv = 1; load_addr = 20; load_data = 32'ha5a5_5a5a; load_be = 4'hf;
        @(negedge clk);
        check("t5_rsp_dropped", fetch_rsp_valid, 0);
        step();
        reset = 0;
        @(negedge clk);
        check("t5_load_first", load_ready, 1);
        check("t5_fetch_second", fetch_req_ready, 0);
        step();
        fv = 0; lv = 0; step();

`ifdef IMEM_ARB_STATS_EN
        // 6: stall and fetch counters
        reset = 1; step(); reset = 0;
        load_lock = 1; step();
        fv = 1; fetch_addr = 8; step(); step(); step();
        fv = 0; load_lock = 0;
        @(negedge clk);
        check("t6_stall_cnt", stat_stall_cnt, 3);
        step();
        fv = 1;
        @(negedge clk);
        check("t6_accept", fetch_req_ready, 1);
        step();
        fv = 0;
        @(negedge clk);
        check("t6_fetch_cnt", stat_fetch_cnt, 1);
        step();
`endif

        step(); step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
